alu_issue_stage: RTL and testbench

//  Decode/issue stage directly upstream of the ALU. Accepts RV32I instruction, PC and register-file operands.

---
 rtl/rv32_pkg.sv | 38 +++
 rtl/rv32_alu_decode.sv | 95 +++++++++
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, ALU op-select constants, immediate extractors and skid-buffer states
// Rev 1.0
`default_nettype none

package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_CLS_ARITH = 2'b01;
  localparam logic [1:0] ALU_CLS_BR    = 2'b11;
  localparam logic [5:0] ALU_S_ADD     = 6'd1;
  localparam logic [5:0] ALU_S_NOP     = 6'd0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_alu_decode.sv
// rv32_alu_decode: combinational RV32I decode into ALU operands, op-select and writeback flags
// Rev 1.0
`default_nettype none

module rv32_alu_decode
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [5:0]      s,
  output logic [4:0]      rd,
  output logic            we,
  output logic            is_branch,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);

  logic [2:0] f3;
  logic [6:0] opcode;

  assign f3        = instr[14:12];
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign br_target = pc + XLEN'(signed'(imm_b(instr)));

  always_comb begin
    a         = '0;
    b         = '0;
    s         = ALU_S_NOP;
    we        = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        a  = rs1_val;
        b  = rs2_val;
        s  = {instr[30], f3, ALU_CLS_ARITH};
        we = 1'b1;
        // funct7 may only be 0000000, or 0100000 for SUB/SRA
        if (instr[31] || (instr[29:25] != 5'd0) ||
            (instr[30] && (f3 != 3'b000) && (f3 != 3'b101)))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        a  = rs1_val;
        b  = XLEN'(signed'(imm_i(instr)));
        s  = {1'b0, f3, ALU_CLS_ARITH};
        we = 1'b1;
        if (f3 == 3'b001) begin
          b = XLEN'(instr[24:20]);
          if (instr[31:25] != 7'd0) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          b    = XLEN'(instr[24:20]);
          s[5] = instr[30];
          if (instr[31] || (instr[29:25] != 5'd0)) illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        a         = rs1_val;
        b         = rs2_val;
        s         = {1'b0, f3, ALU_CLS_BR};
        is_branch = 1'b1;
        if ((f3 == 3'b010) || (f3 == 3'b011)) illegal = 1'b1;
      end
      OPC_LUI: begin
        b  = XLEN'(signed'(imm_u(instr)));
        s  = ALU_S_ADD;
        we = 1'b1;
      end
      OPC_AUIPC: begin
        a  = pc;
        b  = XLEN'(signed'(imm_u(instr)));
        s  = ALU_S_ADD;
        we = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Unsupported encodings become an ALU no-op with no side effects
    if (illegal) begin
      s         = ALU_S_NOP;
      we        = 1'b0;
      is_branch = 1'b0;
    end
    if (rd == 5'd0) we = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage feeding the ALU, with a 2-entry skid buffer at the ID/EX boundary
// Rev 1.0
`default_nettype none

module alu_issue_stage
  import rv32_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [5:0]      alu_s,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_is_branch,
  output logic [XLEN-1:0] out_br_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [5:0]      s;
    logic [4:0]      rd;
    logic            we;
    logic            is_branch;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t      dec_entry;
  entry_t      out_q;
  entry_t      skid_q;
  skid_state_e state_q;
  skid_state_e state_d;
  logic        in_fire;
  logic        out_fire;
  logic        load_out_from_in;
  logic        load_out_from_skid;
  logic        load_skid;

  rv32_alu_decode #(.XLEN(XLEN)) u_decode (
    .instr     (in_instr),
    .pc        (in_pc),
    .rs1_val   (in_rs1_val),
    .rs2_val   (in_rs2_val),
    .a         (dec_entry.a),
    .b         (dec_entry.b),
    .s         (dec_entry.s),
    .rd        (dec_entry.rd),
    .we        (dec_entry.we),
    .is_branch (dec_entry.is_branch),
    .br_target (dec_entry.br_target),
    .illegal   (dec_entry.illegal)
  );
  assign dec_entry.pc = in_pc;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d            = state_q;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            load_out_from_in = 1'b1;
            state_d          = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (out_fire && !in_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire && out_fire) begin
            load_out_from_in = 1'b1;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            load_out_from_skid = 1'b1;
            state_d            = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready is computed from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '{a: '0, b: '0, s: '0, rd: '0, we: 1'b0, is_branch: 1'b0,
                 br_target: '0, pc: RESET_PC, illegal: 1'b0};
      skid_q <= '0;
    end else begin
      if (load_out_from_in)
        out_q <= dec_entry;
      else if (load_out_from_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= dec_entry;
    end
  end

  assign alu_a         = out_q.a;
  assign alu_b         = out_q.b;
  assign alu_s         = out_q.s;
  assign out_rd        = out_q.rd;
  assign out_we        = out_q.we;
  assign out_is_branch = out_q.is_branch;
  assign out_br_target = out_q.br_target;
  assign out_pc        = out_q.pc;
  assign out_illegal   = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a queue-based reference model
// Rev 1.0
`default_nettype none

module tb_alu_issue_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_val = '0;
  logic [31:0] in_rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_s;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_is_branch;
  logic [31:0] out_br_target;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tgt;
    logic [31:0] pc;
    int          s;
    int          rd;
    bit          we;
    bit          br;
    bit          ill;
  } exp_t;

  exp_t mq[$];

  alu_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_val    (in_rs1_val),
    .in_rs2_val    (in_rs2_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_s         (alu_s),
    .out_rd        (out_rd),
    .out_we        (out_we),
    .out_is_branch (out_is_branch),
    .out_br_target (out_br_target),
    .out_pc        (out_pc),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    int          f3;
    int          f7;
    logic [31:0] immi;
    logic [31:0] immb;
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    immi = 32'($signed(ins[31:20]));
    immb = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    e.pc  = pc;
    e.rd  = int'(ins[11:7]);
    e.tgt = pc + immb;
    e.a = 0; e.b = 0; e.s = 0; e.we = 0; e.br = 0; e.ill = 0;
    case (ins[6:0])
      7'b0110011: begin
        e.a = r1; e.b = r2; e.we = 1;
        e.s = (f7 == 32 ? 32 : 0) + f3 * 4 + 1;
        e.ill = !((f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)));
      end
      7'b0010011: begin
        e.a = r1; e.we = 1;
        if (f3 == 1) begin
          e.b = 32'(ins[24:20]); e.s = 5; e.ill = (f7 != 0);
        end else if (f3 == 5) begin
          e.b = 32'(ins[24:20]); e.s = (ins[30] ? 32 : 0) + 21;
          e.ill = !(f7 == 0 || f7 == 32);
        end else begin
          e.b = immi; e.s = f3 * 4 + 1;
        end
      end
      7'b1100011: begin
        e.a = r1; e.b = r2; e.br = 1; e.s = f3 * 4 + 3;
        e.ill = (f3 == 2 || f3 == 3);
      end
      7'b0110111: begin e.b = {ins[31:12], 12'h0}; e.s = 1; e.we = 1; end
      7'b0010111: begin e.a = pc; e.b = {ins[31:12], 12'h0}; e.s = 1; e.we = 1; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.s = 0; e.we = 0; e.br = 0; end
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opc;
    logic [6:0]  f7;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: opc = 7'b0110011;
      1, 2: opc = 7'b0010011;
      3: opc = 7'b1100011;
      4: opc = 7'b0110111;
      5: opc = 7'b0010111;
      default: opc = w[6:0];
    endcase
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      default: f7 = w[31:25];
    endcase
    return {f7, w[24:7], opc};
  endfunction

  task automatic compare_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      check_eq("alu_a", 64'(alu_a), 64'(mq[0].a));
      check_eq("alu_b", 64'(alu_b), 64'(mq[0].b));
      check_eq("alu_s", 64'(alu_s), 64'(mq[0].s));
      check_eq("out_rd", 64'(out_rd), 64'(mq[0].rd));
      check_eq("out_we", 64'(out_we), 64'(mq[0].we));
      check_eq("is_branch", 64'(out_is_branch), 64'(mq[0].br));
      check_eq("br_target", 64'(out_br_target), 64'(mq[0].tgt));
      check_eq("out_pc", 64'(out_pc), 64'(mq[0].pc));
      check_eq("illegal", 64'(out_illegal), 64'(mq[0].ill));
    end
  endtask

  // One clock: drive at negedge, advance the FIFO model at posedge, compare 1ns later
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input bit ordy, input bit fl);
    bit take;
    bit give;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
    out_ready = ordy; flush = fl;
    take = v && (mq.size() < 2);
    give = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (give) void'(mq.pop_front());
      if (take) mq.push_back(ref_decode(ins, pc, r1, r2));
    end
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_a"}, 64'(alu_a), 64'd0);
    check_eq({tag, "_b"}, 64'(alu_b), 64'd0);
    check_eq({tag, "_s"}, 64'(alu_s), 64'd0);
    check_eq({tag, "_rd"}, 64'(out_rd), 64'd0);
    check_eq({tag, "_flags"}, 64'({out_we, out_is_branch, out_illegal}), 64'd0);
    check_eq({tag, "_tgt"}, 64'(out_br_target), 64'd0);
    check_eq({tag, "_pc"}, 64'(out_pc), 64'(RST_PC));
  endtask

  function automatic logic [31:0] addi_rd(input int k);
    logic [4:0] r;
    r = 5'(k);
    return {7'd0, r, 5'd0, 3'b000, r, 7'b0010011};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode cases
    step(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);
    check_eq("add_s", 64'(alu_s), 64'd1);
    check_eq("add_a", 64'(alu_a), 64'd5);
    check_eq("add_b", 64'(alu_b), 64'd7);
    check_eq("add_rd", 64'(out_rd), 64'd3);
    check_eq("add_we", 64'(out_we), 64'd1);
    step(1, 32'h402081B3, 32'h4, 32'd5, 32'd7, 1, 0);
    check_eq("sub_s", 64'(alu_s), 64'd33);
    step(1, 32'h40335293, 32'h8, 32'hFFFF_0000, 32'd0, 1, 0);
    check_eq("srai_s", 64'(alu_s), 64'd53);
    check_eq("srai_b", 64'(alu_b), 64'd3);
    check_eq("srai_rd", 64'(out_rd), 64'd5);
    step(1, 32'h0020C463, 32'h100, 32'd1, 32'd2, 1, 0);
    check_eq("blt_s", 64'(alu_s), 64'd19);
    check_eq("blt_br", 64'(out_is_branch), 64'd1);
    check_eq("blt_we", 64'(out_we), 64'd0);
    check_eq("blt_tgt", 64'(out_br_target), 64'h108);
    step(1, 32'h0000007F, 32'h200, 32'd1, 32'd2, 1, 0);
    check_eq("ill_s", 64'(alu_s), 64'd0);
    check_eq("ill_flag", 64'(out_illegal), 64'd1);
    check_eq("ill_we", 64'(out_we), 64'd0);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Back-pressure: three back-to-back entries, consumer stalled
    step(1, addi_rd(1), 32'h10, 32'd0, 32'd0, 0, 0);
    step(1, addi_rd(2), 32'h14, 32'd0, 32'd0, 0, 0);
    check_eq("bp_ready_full", 64'(in_ready), 64'd0);
    step(1, addi_rd(3), 32'h18, 32'd0, 32'd0, 0, 0);
    check_eq("bp_hold_rd", 64'(out_rd), 64'd1);
    step(1, addi_rd(3), 32'h18, 32'd0, 32'd0, 1, 0);
    check_eq("bp_second_rd", 64'(out_rd), 64'd2);
    step(1, addi_rd(3), 32'h18, 32'd0, 32'd0, 1, 0);
    check_eq("bp_third_rd", 64'(out_rd), 64'd3);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    check_eq("bp_drained", 64'(out_valid), 64'd0);

    // Flush while full with a same-cycle input
    step(1, addi_rd(7), 32'h20, 32'd0, 32'd0, 0, 0);
    step(1, addi_rd(8), 32'h24, 32'd0, 32'd0, 0, 0);
    step(1, addi_rd(9), 32'h28, 32'd0, 32'd0, 0, 1);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Randomized traffic with occasional flush and one asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom} & 32'hFFFF_FFFC,
           $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      if (i == 700) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        mq.delete();
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
